// File: rtl/axis_packetizer_pkg.sv
// Shared types and default widths for the AXI-Stream packetizer.
package axis_packetizer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry (main + skid) stream buffer with a registered ready, so the
// upstream ready never depends combinationally on the downstream ready.
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_allow,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic         o_empty
);

    // A beat transfers on either side only when valid && ready are both high
    // at a rising edge; valid, once raised, holds with stable data until then.
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         ready_q,      ready_d;
    logic         accept;
    logic         pop;

    assign accept = i_valid && ready_q;
    assign pop    = main_valid_q && i_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = i_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: the beat already in flight parks in skid.
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
        end
        ready_d = i_allow && !skid_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = main_valid_q;
    assign o_data  = main_data_q;
    assign o_empty = !main_valid_q && !skid_valid_q;

endmodule

// File: rtl/axis_packetizer.sv
// Groups an incoming AXI-Stream into fixed-length packets with TLAST,
// counting completed packets and raising a sticky completion interrupt.
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_data_last,
    input  logic              i_data_ready,
    input  logic              i_enable,
    input  logic [LEN_W-1:0]  i_pkt_len,
    input  logic              i_intr_clr,
    output logic [31:0]       o_pkt_count,
    output logic              o_busy,
    output logic              o_intr
);

    pkt_state_e        state_q,     state_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [LEN_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic [31:0]       pkt_count_q, pkt_count_d;
    logic              intr_q,      intr_d;

    logic              accept;
    logic              is_last;
    logic              complete;
    logic              buf_empty;
    logic              buf_allow;
    logic [LEN_W-1:0]  pkt_len_eff;
    logic [DATA_W:0]   buf_in;
    logic [DATA_W:0]   buf_out;

    assign accept      = i_data_valid && o_data_ready;
    assign is_last     = (beat_cnt_q == len_q - 1'b1);
    assign pkt_len_eff = (i_pkt_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : i_pkt_len;
    assign complete    = o_data_valid && i_data_ready && o_data_last;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d    = ST_RUN;
                    len_d      = pkt_len_eff;
                    beat_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (is_last) begin
                        beat_cnt_d = '0;
                        // Enable and length only matter at a packet boundary.
                        if (i_enable) begin
                            len_d = pkt_len_eff;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (buf_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pkt_count_d = pkt_count_q + {31'd0, complete};
        intr_d      = complete || (intr_q && !i_intr_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_count_q <= pkt_count_d;
            intr_q      <= intr_d;
        end
    end

    // Ready is computed from the next state so the buffer's registered
    // ready is already correct in the first cycle of RUN and drops in DRAIN.
    assign buf_allow = (state_d == ST_RUN);
    assign buf_in    = {(state_q == ST_RUN) && is_last, i_data};

    axis_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_allow (buf_allow),
        .i_valid (i_data_valid),
        .i_data  (buf_in),
        .o_ready (o_data_ready),
        .o_valid (o_data_valid),
        .o_data  (buf_out),
        .i_ready (i_data_ready),
        .o_empty (buf_empty)
    );

    assign o_data      = buf_out[DATA_W-1:0];
    assign o_data_last = buf_out[DATA_W];
    assign o_pkt_count = pkt_count_q;
    assign o_intr      = intr_q;
    assign o_busy      = ((state_q != ST_IDLE) && ((beat_cnt_q != '0) || !buf_empty))
                         || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_axis_packetizer.sv
// Randomized scoreboard bench for axis_packetizer: a packet-level model
// predicts {last,data} per accepted beat; a monitor checks the output side.
module tb_axis_packetizer;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_data_valid;
    logic [DW-1:0] i_data;
    logic          o_data_ready;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_data_last;
    logic          i_data_ready;
    logic          i_enable;
    logic [LW-1:0] i_pkt_len;
    logic          i_intr_clr;
    logic [31:0]   o_pkt_count;
    logic          o_busy;
    logic          o_intr;

    int checks = 0;
    int errors = 0;

    logic [DW:0]   exp_q[$];
    int            m_left;
    int            exp_pkts;
    logic [LW-1:0] cfg_len;
    int            rdy_mode;

    int            occ;
    logic          stall_pend;
    logic [DW:0]   stall_val;
    logic [DW:0]   want;
    logic          hs;
    logic          acc;

    axis_packetizer #(.DATA_W(DW), .LEN_W(LW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .i_enable     (i_enable),
        .i_pkt_len    (i_pkt_len),
        .i_intr_clr   (i_intr_clr),
        .o_pkt_count  (o_pkt_count),
        .o_busy       (o_busy),
        .o_intr       (o_intr)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int eff_len(input logic [LW-1:0] l);
        return (l == '0) ? 1 : int'(l);
    endfunction

    // downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_data_ready = 1'b1;
                1:       i_data_ready = !i_data_ready;
                2:       i_data_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // monitor: beats in flight, output stability, scoreboard pop
    initial begin
        occ        = 0;
        stall_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ        = 0;
                stall_pend = 1'b0;
            end else begin
                check("valid_vs_in_flight", {63'd0, o_data_valid}, {63'd0, occ != 0});
                if (occ >= 2) check("ready_with_skid_full", {63'd0, o_data_ready}, 64'd0);
                if (stall_pend)
                    check("stall_hold", {o_data_valid, o_data_last, o_data}, {1'b1, stall_val});
                hs  = o_data_valid && i_data_ready;
                acc = i_data_valid && o_data_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: actual=%0h expected=none", {o_data_last, o_data});
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", {31'd0, o_data_last, o_data}, {31'd0, want});
                    end
                end
                stall_pend = o_data_valid && !i_data_ready;
                stall_val  = {o_data_last, o_data};
                occ        = occ + (acc ? 1 : 0) - (hs ? 1 : 0);
            end
        end
    end

    // driver tasks
    task automatic set_len(input logic [LW-1:0] l);
        cfg_len   = l;
        i_pkt_len = l;
    endtask

    task automatic start_run();
        i_enable = 1'b1;
        m_left   = eff_len(cfg_len);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic en);
        int   waited = 0;
        logic lst;
        i_enable     = en;
        i_data       = d;
        i_data_valid = 1'b1;
        @(negedge clk);
        while (!o_data_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!o_data_ready) begin
            errors++;
            $display("FAIL accept_timeout: beat %0h waited=%0d expected<200", d, waited);
        end else begin
            if (m_left == 0) begin
                errors++;
                $display("FAIL accept_outside_packet: beat %0h accepted expected=not accepted", d);
            end
            lst = (m_left == 1);
            exp_q.push_back({lst, d});
            if (lst) begin
                exp_pkts++;
                m_left = en ? eff_len(cfg_len) : 0;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic run(input int n, input int base, input int max_gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_beat(rnd ? $urandom : DW'(base + i), i != n - 1);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("busy_after_drain", {63'd0, o_busy}, 64'd0);
        check("ready_when_idle", {63'd0, o_data_ready}, 64'd0);
        check("pkt_count", {32'd0, o_pkt_count}, 64'(exp_pkts));
    endtask

    task automatic check_reset_state();
        check("rst_ready", {63'd0, o_data_ready}, 64'd0);
        check("rst_valid", {63'd0, o_data_valid}, 64'd0);
        check("rst_last", {63'd0, o_data_last}, 64'd0);
        check("rst_data", {32'd0, o_data}, 64'd0);
        check("rst_count", {32'd0, o_pkt_count}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_intr", {63'd0, o_intr}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        i_data_valid = 1'b0;
        i_data       = '0;
        i_data_ready = 1'b1;
        i_enable     = 1'b0;
        i_pkt_len    = '0;
        i_intr_clr   = 1'b0;
        cfg_len      = '0;
        rdy_mode     = 0;
        m_left       = 0;
        exp_pkts     = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        // continuous len=4 stream, always-ready sink
        set_len(16'd4);
        start_run();
        run(12, 0, 0, 1'b0);
        wait_idle();
        check("intr_after_t1", {63'd0, o_intr}, 64'd1);

        // sink toggles every cycle, random source gaps
        rdy_mode = 1;
        set_len(16'd4);
        start_run();
        run(24, 100, 2, 1'b0);
        wait_idle();

        // random sink, random data, len=3
        rdy_mode = 2;
        set_len(16'd3);
        start_run();
        run(18, 0, 1, 1'b1);
        wait_idle();
        rdy_mode = 0;

        // zero length behaves as one beat per packet
        set_len(16'd0);
        start_run();
        run(5, 200, 0, 1'b0);
        wait_idle();

        // enable drops mid-packet: packet still completes at 8 beats
        set_len(16'd8);
        start_run();
        for (int i = 0; i < 8; i++) send_beat(DW'(300 + i), i <= 3);
        wait_idle();
        i_data_valid = 1'b1;
        i_data       = 32'hdead_beef;
        repeat (8) begin
            @(negedge clk);
            check("ready_low_after_disable", {63'd0, o_data_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;

        // length change mid-packet only affects the next packet
        set_len(16'd4);
        start_run();
        send_beat(32'd400, 1'b1);
        send_beat(32'd401, 1'b1);
        set_len(16'd2);
        for (int i = 2; i < 8; i++) send_beat(DW'(400 + i), i != 7);
        wait_idle();

        // reset mid-packet discards everything
        set_len(16'd4);
        start_run();
        for (int i = 0; i < 3; i++) send_beat(DW'(450 + i), 1'b1);
        rst      = 1'b1;
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        exp_q.delete();
        m_left   = 0;
        exp_pkts = 0;
        start_run();
        run(8, 500, 0, 1'b0);
        wait_idle();
        check("intr_after_restart", {63'd0, o_intr}, 64'd1);

        // clear alone, then clear coincident with a completion
        rdy_mode     = 3;
        i_data_ready = 1'b0;
        i_intr_clr   = 1'b1;
        @(posedge clk);
        #1;
        i_intr_clr = 1'b0;
        check("intr_cleared", {63'd0, o_intr}, 64'd0);
        set_len(16'd1);
        start_run();
        send_beat(32'd600, 1'b0);
        @(posedge clk);
        #1;
        check("intr_before_completion", {63'd0, o_intr}, 64'd0);
        i_data_ready = 1'b1;
        i_intr_clr   = 1'b1;
        @(posedge clk);
        #1;
        i_intr_clr = 1'b0;
        check("intr_set_wins_clear", {63'd0, o_intr}, 64'd1);
        rdy_mode = 0;
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Downstream stage of the counter stream path. Consumes the 32-bit AXI-Stream produced by the counter top-level's output buffer, groups beats into fixed-length packets and drives TLAST on the final beat of each, so the stream can land directly on an AXI DMA S2MM channel. Provides full-throughput, registered-ready buffering, a packet counter and a packet-complete interrupt.

## Interface
- DATA_W, 32, stream data width
- LEN_W, 16, width of the packet-length configuration
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_data_valid  in  1  slave TVALID (from upstream buffer)
- i_data  in  DATA_W  slave TDATA
- o_data_ready  out  1  slave TREADY
- o_data  out  DATA_W  master TDATA (to DMA)
- o_data_valid  out  1  master TVALID
- o_data_last  out  1  master TLAST
- i_data_ready  in  1  master TREADY
- i_enable  in  1  packetizer enable; sampled only at packet boundaries
- i_pkt_len  in  LEN_W  beats per packet; 0 treated as 1; latched at packet start
- i_intr_clr  in  1  clears o_intr
- o_pkt_count  out  32  completed packets since reset, wraps modulo 2^32
- o_busy  out  1  high while a packet is open or data is buffered
- o_intr  out  1  sticky packet-complete interrupt

## Operation
- Reset: o_data_ready=0, o_data_valid=0, o_data_last=0, o_data=0, o_pkt_count=0, o_busy=0, o_intr=0; FSM→IDLE; beat counter=0; both buffer entries empty.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: o_data_ready=0. i_enable=1 → RUN, latch len_q = max(i_pkt_len,1), beat_cnt=0.
  - RUN: accept beats. On accepted beat with beat_cnt==len_q-1: tag beat last, beat_cnt=0; if i_enable=1 re-latch len_q from i_pkt_len (next packet); else → DRAIN. Otherwise beat_cnt+=1.
  - DRAIN: o_data_ready=0; when both buffer entries empty → IDLE.
- i_enable falling mid-packet does not truncate: current packet completes at len_q beats.
- i_pkt_len changes mid-packet ignored until next boundary.
- Buffer: output register (main) plus one skid register. Beat accepted when i_data_valid && o_data_ready. Last flag travels with data.
- Packet completion = output handshake (o_data_valid && i_data_ready) with o_data_last=1: o_pkt_count+=1, o_intr set.
- o_intr: set on completion, cleared by i_intr_clr; simultaneous set and clear → stays set.
- o_busy = (FSM≠IDLE) && (beat_cnt≠0 || any entry valid) or FSM==DRAIN.

## Timing
- o_data_ready is a register output: high in RUN when the skid entry is empty at the previous edge; no combinational path from i_data_ready.
- Latency: beat accepted at edge N appears on o_data/o_data_valid after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while i_data_ready=1.
- i_data_ready low: main holds; one further beat (already in flight) goes to skid; o_data_ready drops next cycle. On i_data_ready high, skid moves to main same edge; o_data_ready returns the cycle after skid empties.
- o_data/o_data_last stable while o_data_valid=1 and i_data_ready=0 (AXI-S rule); o_data_valid never drops without handshake.
- o_pkt_count and o_intr update the cycle after the last-beat output handshake.
- Reset mid-packet: all state cleared same edge; partial packet discarded; no TLAST issued.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DRAIN), default DATA_W/LEN_W constants.
- One sub-module: axis_skid_buffer (2-entry main+skid, DATA_W+1 wide for data+last, registered ready); packetizer FSM and counters in the top.

## Test plan
- Len=4, enable=1, feed 0..11 continuously, i_data_ready=1 → 12 beats out, o_data_last on data 3,7,11; o_pkt_count=3; o_intr=1.
- Len=4, i_data_ready toggles 1/0 every cycle, random i_data_valid → output order 0..N intact, no loss or duplication, data stable while stalled, o_data_ready never high with skid full.
- i_pkt_len=0 → every beat carries o_data_last; 5 beats → o_pkt_count=5.
- Len=8, drop i_enable after beat 3 → beats 4..7 still accepted, last on beat 7, o_data_ready=0 afterwards, FSM returns IDLE, o_busy=0.
- Change i_pkt_len 4→2 after beat 1 of a packet → current packet 4 beats, following packets 2 beats.
- Assert i_rst after beat 2 of len=4 packet → all outputs reset values next cycle; after re-enable, first packet starts at beat_cnt 0 with o_pkt_count=0; i_intr_clr coincident with completion leaves o_intr=1.
